// File: rtl/m68k_bus_ctrl.sv
// fx68k bus controller: phi1/phi2 enables, address decode, DTACK/VPA/BERR
// handshake generation and read-data return from main memory or video RAM.
module m68k_bus_ctrl #(
  parameter int unsigned MEM_WAIT     = 1,
  parameter int unsigned BERR_TIMEOUT = 63,
  parameter logic [7:0]  VRAM_PAGE    = 8'hC0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        phi1,
  output logic        phi2,
  input  logic        cpu_as_n,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic        cpu_rw,
  input  logic [2:0]  cpu_fc,
  input  logic [23:1] cpu_a,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        dtack_n,
  output logic        vpa_n,
  output logic        berr_n,
  output logic        mem_cs,
  output logic [1:0]  mem_we,
  input  logic [15:0] mem_dout,
  output logic [14:0] vram_addr,
  output logic [7:0]  vram_din,
  output logic        vram_wr,
  output logic        vram_rd,
  input  logic [7:0]  vram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM,
    S_VRAM_STB,
    S_VRAM_DATA,
    S_UNMAPPED,
    S_ACK
  } state_e;

  state_e      state_q, state_d;
  logic        phi1_q, phi1_d;
  logic        phi2_q, phi2_d;
  logic        dtack_n_q, dtack_n_d;
  logic        vpa_n_q, vpa_n_d;
  logic        berr_n_q, berr_n_d;
  logic        mem_cs_q, mem_cs_d;
  logic [1:0]  mem_we_q, mem_we_d;
  logic [14:0] vram_addr_q, vram_addr_d;
  logic [7:0]  vram_din_q, vram_din_d;
  logic        vram_wr_q, vram_wr_d;
  logic        vram_rd_q, vram_rd_d;
  logic [15:0] cpu_din_q, cpu_din_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;

  localparam logic [7:0] MEM_WAIT_CNT = 8'(MEM_WAIT);
  localparam logic [7:0] BERR_LAST    = 8'(BERR_TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phi1_q      <= 1'b0;
      phi2_q      <= 1'b0;
      dtack_n_q   <= 1'b1;
      vpa_n_q     <= 1'b1;
      berr_n_q    <= 1'b1;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 2'b00;
      vram_addr_q <= '0;
      vram_din_q  <= '0;
      vram_wr_q   <= 1'b0;
      vram_rd_q   <= 1'b0;
      cpu_din_q   <= '0;
      cnt_q       <= '0;
      rw_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      phi1_q      <= phi1_d;
      phi2_q      <= phi2_d;
      dtack_n_q   <= dtack_n_d;
      vpa_n_q     <= vpa_n_d;
      berr_n_q    <= berr_n_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      vram_addr_q <= vram_addr_d;
      vram_din_q  <= vram_din_d;
      vram_wr_q   <= vram_wr_d;
      vram_rd_q   <= vram_rd_d;
      cpu_din_q   <= cpu_din_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    // Both enables are low in reset, so the first post-reset clk yields phi1.
    phi1_d      = ~phi1_q;
    phi2_d      = phi1_q;
    dtack_n_d   = dtack_n_q;
    vpa_n_d     = vpa_n_q;
    berr_n_d    = berr_n_q;
    mem_cs_d    = mem_cs_q;
    mem_we_d    = 2'b00;
    vram_addr_d = vram_addr_q;
    vram_din_d  = vram_din_q;
    vram_wr_d   = 1'b0;
    vram_rd_d   = 1'b0;
    cpu_din_d   = cpu_din_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;

    case (state_q)
      S_IDLE: begin
        if (!cpu_as_n) begin
          cnt_d = '0;
          rw_d  = cpu_rw;
          if (cpu_fc == 3'b111) begin
            vpa_n_d = 1'b0;
            state_d = S_ACK;
          end else if (!cpu_a[23]) begin
            mem_cs_d = 1'b1;
            if (!cpu_rw) mem_we_d = {~cpu_uds_n, ~cpu_lds_n};
            state_d = S_MEM;
          end else if (cpu_a[23:16] == VRAM_PAGE && !cpu_a[15]) begin
            // Upper strobe wins when both are low, giving the even byte.
            vram_addr_d = {cpu_a[14:1], cpu_uds_n};
            if (!cpu_rw) begin
              vram_din_d = cpu_uds_n ? cpu_dout[7:0] : cpu_dout[15:8];
              vram_wr_d  = 1'b1;
            end else begin
              vram_rd_d  = 1'b1;
            end
            state_d = S_VRAM_STB;
          end else begin
            state_d = S_UNMAPPED;
          end
        end
      end

      S_MEM: begin
        if (cpu_as_n) begin
          mem_cs_d = 1'b0;
          state_d  = S_IDLE;
        end else if (cnt_q == MEM_WAIT_CNT) begin
          cpu_din_d = mem_dout;
          dtack_n_d = 1'b0;
          state_d   = S_ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_VRAM_STB: begin
        state_d = cpu_as_n ? S_IDLE : S_VRAM_DATA;
      end

      S_VRAM_DATA: begin
        if (cpu_as_n) begin
          state_d = S_IDLE;
        end else begin
          if (rw_q) cpu_din_d = {vram_dout, vram_dout};
          dtack_n_d = 1'b0;
          state_d   = S_ACK;
        end
      end

      S_UNMAPPED: begin
        if (cpu_as_n) begin
          state_d = S_IDLE;
        end else if (cnt_q == BERR_LAST) begin
          berr_n_d = 1'b0;
          state_d  = S_ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_ACK: begin
        if (cpu_as_n) begin
          dtack_n_d = 1'b1;
          vpa_n_d   = 1'b1;
          berr_n_d  = 1'b1;
          mem_cs_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign phi1      = phi1_q;
  assign phi2      = phi2_q;
  assign dtack_n   = dtack_n_q;
  assign vpa_n     = vpa_n_q;
  assign berr_n    = berr_n_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign vram_addr = vram_addr_q;
  assign vram_din  = vram_din_q;
  assign vram_wr   = vram_wr_q;
  assign vram_rd   = vram_rd_q;
  assign cpu_din   = cpu_din_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed self-checking bench for m68k_bus_ctrl with default parameters
// (MEM_WAIT=1, BERR_TIMEOUT=63, VRAM_PAGE=C0) and registered memory models.
module tb_m68k_bus_ctrl;

  logic        clk;
  logic        reset;
  logic        phi1, phi2;
  logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw;
  logic [2:0]  cpu_fc;
  logic [23:1] cpu_a;
  logic [15:0] cpu_dout;
  logic [15:0] cpu_din;
  logic        dtack_n, vpa_n, berr_n;
  logic        mem_cs;
  logic [1:0]  mem_we;
  logic [15:0] mem_dout;
  logic [14:0] vram_addr;
  logic [7:0]  vram_din;
  logic        vram_wr, vram_rd;
  logic [7:0]  vram_dout;

  logic [15:0] mem_rdata;
  logic [7:0]  vram_rdata;

  int checks;
  int failures;

  m68k_bus_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .phi1      (phi1),
    .phi2      (phi2),
    .cpu_as_n  (cpu_as_n),
    .cpu_uds_n (cpu_uds_n),
    .cpu_lds_n (cpu_lds_n),
    .cpu_rw    (cpu_rw),
    .cpu_fc    (cpu_fc),
    .cpu_a     (cpu_a),
    .cpu_dout  (cpu_dout),
    .cpu_din   (cpu_din),
    .dtack_n   (dtack_n),
    .vpa_n     (vpa_n),
    .berr_n    (berr_n),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout),
    .vram_addr (vram_addr),
    .vram_din  (vram_din),
    .vram_wr   (vram_wr),
    .vram_rd   (vram_rd),
    .vram_dout (vram_dout)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Synchronous memories: data appears one clk after the select/strobe.
  always @(posedge clk) begin
    mem_dout  <= mem_cs  ? mem_rdata  : 16'h0000;
    vram_dout <= vram_rd ? vram_rdata : 8'h00;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic as_n, input logic uds_n, input logic lds_n,
                               input logic rw, input logic [2:0] fc,
                               input logic [23:0] addr, input logic [15:0] dout);
    cpu_as_n  = as_n;
    cpu_uds_n = uds_n;
    cpu_lds_n = lds_n;
    cpu_rw    = rw;
    cpu_fc    = fc;
    cpu_a     = addr[23:1];
    cpu_dout  = dout;
  endtask

  task automatic releaseBus();
    cpu_as_n  = 1'b1;
    cpu_uds_n = 1'b1;
    cpu_lds_n = 1'b1;
    cpu_rw    = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic early_berr;
    logic other_ack;
    logic [1:0] phase_exp;

    checks     = 0;
    failures   = 0;
    mem_rdata  = 16'h0000;
    vram_rdata = 8'h00;
    reset      = 1'b1;
    cpu_fc     = 3'b101;
    cpu_a      = '0;
    cpu_dout   = '0;
    releaseBus();

    stepClock();
    stepClock();
    checkOutput("reset_phi", {phi1, phi2}, 2'b00);
    checkOutput("reset_acks", {dtack_n, vpa_n, berr_n}, 3'b111);
    checkOutput("reset_mem", {mem_cs, mem_we}, 3'b000);
    checkOutput("reset_vram", {vram_wr, vram_rd, vram_addr, vram_din}, 25'h0);
    checkOutput("reset_din", cpu_din, 16'h0000);

    $display("[TB] phase sequence after reset release");
    reset = 1'b0;
    phase_exp = 2'b10;
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checkOutput("phase", {phi1, phi2}, phase_exp);
      phase_exp = {phase_exp[0], phase_exp[1]};
    end

    $display("[TB] main memory read 0x000100");
    mem_rdata = 16'h4E71;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 24'h000100, 16'h0000);
    stepClock();
    checkOutput("mrd_e0_cs", {mem_cs, dtack_n, mem_we}, 4'b1100);
    stepClock();
    checkOutput("mrd_e1_dtack", {mem_cs, dtack_n}, 2'b11);
    stepClock();
    checkOutput("mrd_e2_dtack", {mem_cs, dtack_n, vpa_n, berr_n}, 4'b1011);
    checkOutput("mrd_data", cpu_din, 16'h4E71);
    stepClock();
    checkOutput("mrd_hold", {mem_cs, dtack_n}, 2'b10);
    releaseBus();
    stepClock();
    checkOutput("mrd_release", {mem_cs, dtack_n}, 2'b01);
    stepClock();
    checkOutput("mrd_din_hold", cpu_din, 16'h4E71);

    $display("[TB] main memory word write 0x000200");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 24'h000200, 16'hA55A);
    stepClock();
    checkOutput("mwr_we_e0", mem_we, 2'b11);
    stepClock();
    checkOutput("mwr_we_e1", mem_we, 2'b00);
    stepClock();
    checkOutput("mwr_dtack", {mem_we, dtack_n}, 3'b000);
    releaseBus();
    stepClock();
    checkOutput("mwr_release", {mem_cs, dtack_n}, 2'b01);

    $display("[TB] main memory lower byte write 0x000200");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 24'h000200, 16'h005A);
    stepClock();
    checkOutput("mwrl_we_e0", mem_we, 2'b01);
    stepClock();
    checkOutput("mwrl_we_e1", mem_we, 2'b00);
    stepClock();
    checkOutput("mwrl_dtack", dtack_n, 1'b0);
    releaseBus();
    stepClock();

    $display("[TB] video RAM lower byte write 0xC00010");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 24'hC00010, 16'h12AB);
    stepClock();
    checkOutput("vwr_e0_wr", {vram_wr, vram_rd, mem_cs, dtack_n}, 4'b1001);
    checkOutput("vwr_addr", vram_addr, 15'h0011);
    checkOutput("vwr_din", vram_din, 8'hAB);
    stepClock();
    checkOutput("vwr_e1", {vram_wr, dtack_n}, 2'b01);
    stepClock();
    checkOutput("vwr_e2", {vram_wr, dtack_n}, 2'b00);
    releaseBus();
    stepClock();
    checkOutput("vwr_release", dtack_n, 1'b1);

    $display("[TB] video RAM upper byte read 0xC00010");
    vram_rdata = 8'h77;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 24'hC00010, 16'h0000);
    stepClock();
    checkOutput("vrd_e0_rd", {vram_rd, vram_wr, dtack_n}, 3'b101);
    checkOutput("vrd_addr", vram_addr, 15'h0010);
    stepClock();
    checkOutput("vrd_e1", {vram_rd, dtack_n}, 2'b01);
    stepClock();
    checkOutput("vrd_e2_dtack", dtack_n, 1'b0);
    checkOutput("vrd_data", cpu_din, 16'h7777);
    releaseBus();
    stepClock();
    checkOutput("vrd_release", dtack_n, 1'b1);

    $display("[TB] unmapped read 0x900000");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 24'h900000, 16'h0000);
    stepClock();
    early_berr = 1'b0;
    other_ack  = 1'b0;
    for (int i = 1; i < 63; i++) begin
      stepClock();
      if (!berr_n) early_berr = 1'b1;
      if (!dtack_n || !vpa_n || mem_cs || mem_we != 2'b00) other_ack = 1'b1;
    end
    checkOutput("unm_berr_early", early_berr, 1'b0);
    stepClock();
    checkOutput("unm_berr_63", {berr_n, dtack_n, vpa_n}, 3'b011);
    stepClock();
    checkOutput("unm_berr_hold", berr_n, 1'b0);
    if (!dtack_n || !vpa_n) other_ack = 1'b1;
    checkOutput("unm_other_acks", other_ack, 1'b0);
    releaseBus();
    stepClock();
    checkOutput("unm_release", berr_n, 1'b1);

    $display("[TB] interrupt acknowledge");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 24'hFFFFF6, 16'h0000);
    stepClock();
    checkOutput("iack_e0", {vpa_n, dtack_n, berr_n, mem_cs}, 4'b0110);
    stepClock();
    stepClock();
    checkOutput("iack_hold", vpa_n, 1'b0);
    releaseBus();
    cpu_fc = 3'b101;
    stepClock();
    checkOutput("iack_release", vpa_n, 1'b1);

    $display("[TB] aborted main memory read");
    mem_rdata = 16'hBEEF;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 24'h000100, 16'h0000);
    stepClock();
    releaseBus();
    stepClock();
    checkOutput("abort_e1", {mem_cs, dtack_n}, 2'b01);
    stepClock();
    checkOutput("abort_e2", {mem_cs, dtack_n, cpu_din}, {2'b01, 16'h7777});

    $display("[TB] reset during video RAM read");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 24'hC00010, 16'h0000);
    stepClock();
    checkOutput("rst_vrd_e0", vram_rd, 1'b1);
    reset = 1'b1;
    stepClock();
    checkOutput("rst_vrd_after", {vram_rd, dtack_n, phi1, phi2}, 4'b0100);
    reset = 1'b0;
    releaseBus();
    stepClock();
    checkOutput("rst_phi_restart", {phi1, phi2}, 2'b10);
    mem_rdata = 16'h1234;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 24'h000100, 16'h0000);
    stepClock();
    checkOutput("rst_mrd_e0", {mem_cs, dtack_n}, 2'b11);
    stepClock();
    checkOutput("rst_mrd_e1", dtack_n, 1'b1);
    stepClock();
    checkOutput("rst_mrd_e2", {dtack_n, cpu_din}, {1'b0, 16'h1234});
    releaseBus();
    stepClock();
    checkOutput("rst_mrd_release", {mem_cs, dtack_n}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
